serial_sub4: RTL and testbench

SERIAL_SUB4 -- requirements
Module: serial_sub4

---
 rtl/serial_sub4_pkg.sv | 18 +
 rtl/serial_sub4_fs.sv | 13 +
 rtl/serial_sub4.sv | 111 +++++++++++
 tb/tb_serial_sub4.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub4_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub4_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_w(WIDTH_DEF);

endpackage

// File: rtl/serial_sub4_fs.sv
// One-bit full subtractor used once per serial step.
module full_subtractor (
  output logic diff,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial a - b - bin, LSB first, one bit per clock.
module serial_sub4
  import serial_sub4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fs_diff, fs_bout;
  logic             last;
  logic             accept;

  full_subtractor u_fs (
    .diff (fs_diff),
    .bout (fs_bout),
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (brw_q)
  );

  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign accept = start && (state_q != SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result bits enter the minuend register from the top as it drains.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    d_d    = d_q;
    brw_d  = brw_q;
    bout_d = bout_q;
    cnt_d  = cnt_q;
    if (accept) begin
      a_d   = a;
      b_d   = b;
      brw_d = bin;
      cnt_d = '0;
    end else if (state_q == SHIFT) begin
      a_d   = {fs_diff, a_q[WIDTH-1:1]};
      b_d   = {1'b0, b_q[WIDTH-1:1]};
      brw_d = fs_bout;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        d_d    = a_d;
        bout_d = fs_bout;
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state_q == SHIFT): busy = 1'b1;
      (state_q == DONE):  done = 1'b1;
      default: ;
    endcase
  end

  assign d    = d_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub4.sv
// Self-checking bench for serial_sub4.
module tb_serial_sub4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a, b;
  logic       bin;
  logic [3:0] d;
  logic       bout, busy, done;

  int checks = 0;
  int errors = 0;

  serial_sub4 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .d     (d),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] d;
    logic       bout;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called mid-cycle; returns mid-cycle in the DONE cycle (or on timeout).
  task automatic run_op(
    input  logic [3:0] ia, ib,
    input  logic       ibin,
    output logic [3:0] rd,
    output logic       rb,
    output int         lat,
    output int         bcnt
  );
    start = 1'b1;
    a = ia;
    b = ib;
    bin = ibin;
    tick();
    start = 1'b0;
    a = ~ia;
    b = ~ib;
    bin = ~ibin;
    lat = 0;
    bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    rd = d;
    rb = bout;
  endtask

  vec_t       vt[7];
  logic [3:0] rd;
  logic       rb;
  int         lat, bcnt;
  logic [4:0] ref5;
  int         t1, t2, cyc, pulses;

  initial begin
    vt[0] = '{4'b1001, 4'b0011, 1'b0, 4'b0110, 1'b0};
    vt[1] = '{4'b0011, 4'b1001, 1'b0, 4'b1010, 1'b1};
    vt[2] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1};
    vt[3] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};
    vt[4] = '{4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0};
    vt[5] = '{4'b0111, 4'b0101, 1'b1, 4'b0001, 1'b0};
    vt[6] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    #12;
    chk("rst_d", d, 0);
    chk("rst_bout", bout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);

    // Table vectors, each followed by an idle cycle.
    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].bin, rd, rb, lat, bcnt);
      chk($sformatf("v%0d_lat", i), lat, 4);
      chk($sformatf("v%0d_busy", i), bcnt, 4);
      chk($sformatf("v%0d_d", i), rd, vt[i].d);
      chk($sformatf("v%0d_bout", i), rb, vt[i].bout);
      tick();
      chk($sformatf("v%0d_pulse", i), done, 0);
      chk($sformatf("v%0d_hold_d", i), d, vt[i].d);
      chk($sformatf("v%0d_hold_b", i), bout, vt[i].bout);
    end

    // Start during SHIFT is ignored.
    start = 1'b1;
    a = 4'b1111;
    b = 4'b0001;
    bin = 1'b0;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    a = 4'b0000;
    b = 4'b1111;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          chk("ign_d", d, 4'b1110);
          chk("ign_bout", bout, 0);
        end
      end
      tick();
    end
    chk("ign_pulses", pulses, 1);

    // Asynchronous reset mid-SHIFT.
    start = 1'b1;
    a = 4'b1000;
    b = 4'b0001;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_d", d, 0);
    chk("arst_bout", bout, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done) pulses++;
    end
    chk("arst_nodone", pulses, 0);
    run_op(4'b0101, 4'b0010, 1'b0, rd, rb, lat, bcnt);
    chk("arst_lat", lat, 4);
    chk("arst_next_d", rd, 4'b0011);
    chk("arst_next_b", rb, 0);
    tick();

    // Back-to-back via DONE.
    run_op(4'b0110, 4'b0001, 1'b0, rd, rb, lat, bcnt);
    chk("b2b_d1", rd, 4'b0101);
    t1 = 0;
    start = 1'b1;
    a = 4'b0010;
    b = 4'b0101;
    bin = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    cyc = 1;
    t2 = -1;
    while (t2 < 0 && cyc < 20) begin
      if (done) t2 = cyc;
      else begin
        tick();
        cyc++;
      end
    end
    chk("b2b_gap", t2 - t1, 5);
    chk("b2b_d2", d, 4'b1100);
    chk("b2b_b2", bout, 1);
    tick();

    // Exhaustive sweep against an arithmetic reference.
    for (int x = 0; x < 512; x++) begin
      logic [3:0] ea, eb;
      logic       ebin;
      ea = x[8:5];
      eb = x[4:1];
      ebin = x[0];
      ref5 = {1'b0, ea} - {1'b0, eb} - {4'b0, ebin};
      run_op(ea, eb, ebin, rd, rb, lat, bcnt);
      chk($sformatf("ex%0d_lat", x), lat, 4);
      chk($sformatf("ex%0d_d", x), rd, ref5[3:0]);
      chk($sformatf("ex%0d_b", x), rb, ref5[4]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
